obi_uart_bridge: RTL and testbench
==================================

// Module: obi_uart_bridge
// PURPOSE
//  Host-side bus initiator: parses byte-stream command frames from a UART receiver
//  and issues single-word OBI (req/gnt/rvalid) reads/writes on the SoC bus.
//  Read data and acks return as bytes to a UART transmitter.
//  Sits beside the CPU as a second bus master, for debug/firmware loading.
// PARAMETERS
//  ADDR_WIDTH      32    OBI address width
//  TIMEOUT_CYCLES  1024  cycles waited for gnt or rvalid before abort (macro only)
// PORTS
//  clk_i       in   1           clock
//  rst_ni      in   1           reset, asynchronous, active-low
//  rx_data_i   in   8           received byte
//  rx_valid_i  in   1           rx byte valid
//  rx_ready_o  out  1           bridge accepts rx byte (transfer = valid&ready)
//  tx_data_o   out  8           byte to transmit
//  tx_valid_o  out  1           tx byte valid
//  tx_ready_i  in   1           transmitter accepts byte
//  obi_req_o   out  1           OBI request
//  obi_gnt_i   in   1           OBI grant
//  obi_addr_o  out  ADDR_WIDTH  word address, bits[1:0] always 0
//  obi_we_o    out  1           1=write
//  obi_be_o    out  4           always 4'hF
//  obi_wdata_o out  32          write data
//  obi_rvalid_i in  1           response valid
//  obi_rdata_i in   32          read data
//  busy_o      out  1           high in any state except IDLE
// BEHAVIOUR
//  Frames, all multi-byte fields little-endian:
//   0x57 'W' + 4 addr + 4 data -> bus write, reply 0x4B 'K'
//   0x52 'R' + 4 addr          -> bus read, reply rdata[7:0],[15:8],[23:16],[31:24]
//   any other first byte       -> discarded, reply 0x3F '?'
//  FSM: IDLE -> ADDR (4 bytes) -> [WDATA (4 bytes), writes only] -> REQ -> RVALID -> RESP -> IDLE.
//  2-bit byte counter; clears on each state entry.
//  rx_ready_o=1 only in IDLE/ADDR/WDATA; rx bytes in other states are back-pressured, never dropped.
//  REQ: obi_req_o=1; addr/we/be/wdata held stable until gnt sampled high.
//   Next cycle -> RVALID with req=0; only one outstanding transaction ever.
//  RVALID: waits for obi_rvalid_i, earliest the cycle after gnt.
//   Reads latch obi_rdata_i on rvalid. Writes ignore rdata.
//   rvalid outside RVALID state is ignored.
//  RESP: tx_valid_o=1, tx_data_o stable until tx_ready_i.
//   Read response: 4 bytes; write response: 1 byte. Then IDLE.
//  Unknown command: IDLE -> RESP (1 byte '?') -> IDLE.
//  Address latched as {addr[ADDR_WIDTH-1:2],2'b00}. Bits above 32 zero-extended.
//  Reset (any state, incl. mid-frame or mid-transaction): state=IDLE, counters=0.
//   All outputs 0 except rx_ready_o=1. Partial frame discarded.
// CONFIGURATION
//  BRIDGE_TIMEOUT_EN defined: TIMEOUT_CYCLES-wide counter clears on REQ/RVALID entry.
//   Counts in REQ and RVALID. Reaching TIMEOUT_CYCLES -> req dropped, RESP sends 0x45 'E', -> IDLE.
//   A late rvalid is ignored.
//  BRIDGE_TIMEOUT_EN undefined: no counter; bridge waits indefinitely for gnt/rvalid.
// TESTING
//  1 Write: rx 57 10 00 00 00 EF BE AD DE, gnt 1 cycle after req, rvalid next
//    -> one req, addr=0x00000010, we=1, wdata=0xDEADBEEF; tx 4B.
//  2 Read: rx 52 04 00 00 0F, rdata=0x00000001 -> we=0, addr=0x0F000004; tx 01 00 00 00.
//  3 Unknown 0x33 then valid read frame -> tx 3F, then read handled normally.
//  4 Stalls: gnt after 5 cycles, tx_ready_i low 3 cycles per byte
//    -> req/addr stable until gnt; tx bytes neither lost nor duplicated.
//  5 Reset mid-frame: rst_ni low after 57 10 00 -> outputs at reset values.
//    Next full read frame executes correctly.
//  6 (BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16) read, gnt never -> req drops after 16 cycles; tx 45.

Source files
------------

// File: rtl/obi_uart_bridge.sv
// UART byte-stream to OBI single-word initiator for debug access and firmware loading.
// Optional gnt/rvalid watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module obi_uart_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32
`ifdef BRIDGE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_valid_i,
   output logic                  rx_ready_o,
   output logic [7:0]            tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   output logic                  obi_req_o,
   input  logic                  obi_gnt_i,
   output logic [ADDR_WIDTH-1:0] obi_addr_o,
   output logic                  obi_we_o,
   output logic [3:0]            obi_be_o,
   output logic [31:0]           obi_wdata_o,
   input  logic                  obi_rvalid_i,
   input  logic [31:0]           obi_rdata_i,
   output logic                  busy_o
);

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h4B;
   localparam logic [7:0] RSP_UNK   = 8'h3F;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      WDATA,
      REQ,
      RVALID,
      RESP
   } state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  last_q, last_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] resp_q, resp_d;
   logic        req_q, req_d;
   logic        rx_ready_q, rx_ready_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q, busy_d;
   logic        rx_fire;
   logic        tx_fire;

`ifdef BRIDGE_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [7:0]  RSP_ERR = 8'h45;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_hit;
   assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

   assign rx_fire = rx_valid_i & rx_ready_q;
   assign tx_fire = tx_valid_q & tx_ready_i;

   // Frame parser, bus handshake and reply sequencer; outputs are decoded from the next state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      resp_d  = resp_q;
`ifdef BRIDGE_TIMEOUT_EN
      tmo_d   = '0;
`endif
      unique case (state_q)
         IDLE: begin
            if (rx_fire) begin
               if (rx_data_i == CMD_WRITE) begin
                  we_d    = 1'b1;
                  state_d = ADDR;
               end else if (rx_data_i == CMD_READ) begin
                  we_d    = 1'b0;
                  state_d = ADDR;
               end else begin
                  resp_d  = {24'h0, RSP_UNK};
                  last_d  = 2'd0;
                  state_d = RESP;
               end
            end
         end
         ADDR: begin
            if (rx_fire) begin
               // the two address LSBs are forced to zero as the first byte arrives
               if (cnt_q == 2'd0) begin
                  addr_d[7:0] = {rx_data_i[7:2], 2'b00};
               end else begin
                  addr_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
               end
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = we_q ? WDATA : REQ;
               end
            end
         end
         WDATA: begin
            if (rx_fire) begin
               wdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (obi_gnt_i) begin
               state_d = RVALID;
`ifdef BRIDGE_TIMEOUT_EN
            end else if (tmo_hit) begin
               resp_d  = {24'h0, RSP_ERR};
               last_d  = 2'd0;
               state_d = RESP;
`endif
            end
         end
         RVALID: begin
            if (obi_rvalid_i) begin
               if (we_q) begin
                  resp_d = {24'h0, RSP_ACK};
                  last_d = 2'd0;
               end else begin
                  resp_d = obi_rdata_i;
                  last_d = 2'd3;
               end
               state_d = RESP;
`ifdef BRIDGE_TIMEOUT_EN
            end else if (tmo_hit) begin
               resp_d  = {24'h0, RSP_ERR};
               last_d  = 2'd0;
               state_d = RESP;
`endif
            end
         end
         RESP: begin
            if (tx_fire) begin
               if (cnt_q == last_q) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         cnt_d = 2'd0;
      end
`ifdef BRIDGE_TIMEOUT_EN
      if ((state_d == REQ || state_d == RVALID) && state_d == state_q) begin
         tmo_d = tmo_q + 1'b1;
      end
`endif

      req_d      = (state_d == REQ);
      rx_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
      tx_valid_d = (state_d == RESP);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         last_q     <= 2'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         resp_q     <= 32'h0;
         req_q      <= 1'b0;
         rx_ready_q <= 1'b1;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
         tmo_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         resp_q     <= resp_d;
         req_q      <= req_d;
         rx_ready_q <= rx_ready_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
`ifdef BRIDGE_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
      end
   end

   generate
      if (ADDR_WIDTH > 32) begin : g_addr_wide
         assign obi_addr_o = {{(ADDR_WIDTH - 32){1'b0}}, addr_q};
      end else begin : g_addr_narrow
         assign obi_addr_o = addr_q[ADDR_WIDTH-1:0];
      end
   endgenerate

   assign rx_ready_o  = rx_ready_q;
   assign tx_valid_o  = tx_valid_q;
   assign tx_data_o   = resp_q[{cnt_q, 3'b000} +: 8];
   assign obi_req_o   = req_q;
   assign obi_we_o    = we_q;
   // byte enables are only meaningful while a request is on the bus
   assign obi_be_o    = {4{req_q}};
   assign obi_wdata_o = wdata_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_obi_uart_bridge.sv
// Randomized self-checking bench for obi_uart_bridge: frame-level model predicts bus
// transactions and reply bytes; bus responder and tx sink apply random stalls.
module tb_obi_uart_bridge;

   logic        clk_i;
   logic        rst_ni;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        obi_req_o;
   logic        obi_gnt_i;
   logic [31:0] obi_addr_o;
   logic        obi_we_o;
   logic [3:0]  obi_be_o;
   logic [31:0] obi_wdata_o;
   logic        obi_rvalid_i;
   logic [31:0] obi_rdata_i;
   logic        busy_o;

   obi_uart_bridge #(
      .ADDR_WIDTH(32)
`ifdef BRIDGE_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(16)
`endif
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .rx_data_i   (rx_data_i),
      .rx_valid_i  (rx_valid_i),
      .rx_ready_o  (rx_ready_o),
      .tx_data_o   (tx_data_o),
      .tx_valid_o  (tx_valid_o),
      .tx_ready_i  (tx_ready_i),
      .obi_req_o   (obi_req_o),
      .obi_gnt_i   (obi_gnt_i),
      .obi_addr_o  (obi_addr_o),
      .obi_we_o    (obi_we_o),
      .obi_be_o    (obi_be_o),
      .obi_wdata_o (obi_wdata_o),
      .obi_rvalid_i(obi_rvalid_i),
      .obi_rdata_i (obi_rdata_i),
      .busy_o      (busy_o)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   int          checks = 0;
   int          errors = 0;
   txn_t        expTxn[$];
   logic [7:0]  expReply[$];
   logic [7:0]  expBytes[$];
   logic [31:0] readData[$];
   logic [7:0]  frame[$];
   int          gntDelay = -1;
   bit          stallMode = 0;
   bit          busMute = 0;
   bit          fixedRdata = 0;
   logic [31:0] fixedRdataVal = 32'h0;
   bit          gapEn = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 50000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one rx byte starting at a negedge; returns at the negedge after the transfer
   task automatic applyStimulus(input logic [7:0] b);
      int n = 0;
      rx_data_i  = b;
      rx_valid_i = 1'b1;
      while (!rx_ready_o && n < 2000) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput("rx_accept_bound", 64'(n < 2000), 64'd1);
      @(negedge clk_i);
      rx_valid_i = 1'b0;
   endtask

   // Frame-level model: predict the bus transaction and reply, then send the bytes
   task automatic runFrame();
      txn_t t;
      if (frame[0] == 8'h57 || frame[0] == 8'h52) begin
         t.we    = (frame[0] == 8'h57);
         t.addr  = {frame[4], frame[3], frame[2], frame[1]} & 32'hFFFF_FFFC;
         t.wdata = t.we ? {frame[8], frame[7], frame[6], frame[5]} : 32'h0;
         expTxn.push_back(t);
         expReply.push_back(t.we ? 8'h4B : 8'h52);
      end else begin
         expReply.push_back(8'h3F);
      end
      foreach (frame[i]) begin
         if (gapEn && $urandom_range(0, 3) == 0) @(negedge clk_i);
         applyStimulus(frame[i]);
      end
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while ((busy_o || expTxn.size() != 0 || expReply.size() != 0 || expBytes.size() != 0) && n < 4000) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput(tag, 64'(expTxn.size() + expReply.size() + expBytes.size() + int'(busy_o)), 64'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_rx_ready"}, 64'(rx_ready_o), 64'd1);
      checkOutput({tag, "_outs"},
                  {20'h0, tx_valid_o, tx_data_o, obi_req_o, obi_we_o, obi_be_o, busy_o},
                  64'h0);
      checkOutput({tag, "_addr_wdata"}, {obi_addr_o, obi_wdata_o}, 64'h0);
   endtask

   // OBI target: random or fixed grant delay, checks request against model, random rdata
   initial begin
      int          d;
      logic [31:0] a0;
      logic [31:0] w0;
      logic        we0;
      logic [31:0] rd;
      txn_t        t;
      obi_gnt_i    = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_rdata_i  = 32'h0;
      forever begin
         @(negedge clk_i);
         obi_rvalid_i = 1'b0;
         if (rst_ni && obi_req_o && !busMute) begin
            d   = stallMode ? 5 : (gntDelay >= 0 ? gntDelay : $urandom_range(0, 3));
            a0  = obi_addr_o;
            w0  = obi_wdata_o;
            we0 = obi_we_o;
            repeat (d) begin
               @(negedge clk_i);
               checkOutput("req_hold", {obi_req_o, rx_ready_o, we0, obi_addr_o, obi_wdata_o[28:0]},
                           {1'b1, 1'b0, obi_we_o, a0, w0[28:0]});
            end
            obi_gnt_i = 1'b1;
            if (expTxn.size() == 0) begin
               checkOutput("bus_unexpected_req", 64'd1, 64'd0);
               t.we = 1'b0; t.addr = 32'h0; t.wdata = 32'h0;
            end else begin
               t = expTxn.pop_front();
               checkOutput("bus_addr", 64'(obi_addr_o), 64'(t.addr));
               checkOutput("bus_we_be", {obi_we_o, obi_be_o}, {t.we, 4'hF});
               if (t.we) checkOutput("bus_wdata", 64'(obi_wdata_o), 64'(t.wdata));
            end
            @(negedge clk_i);
            obi_gnt_i = 1'b0;
            checkOutput("req_drop", 64'(obi_req_o), 64'd0);
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            rd = fixedRdata ? fixedRdataVal : $urandom;
            obi_rvalid_i = 1'b1;
            obi_rdata_i  = rd;
            if (!t.we) readData.push_back(rd);
            @(negedge clk_i);
            obi_rvalid_i = 1'b0;
         end else if ($urandom_range(0, 7) == 0) begin
            obi_rvalid_i = 1'b1;
            obi_rdata_i  = $urandom;
         end
      end
   end

   // UART tx sink: random or patterned back-pressure, checks each byte against the model
   initial begin
      bit         prevPending = 0;
      logic [7:0] prevData = 8'h0;
      logic [7:0] want;
      logic [7:0] kind;
      logic [31:0] rd;
      int         stallCnt = 0;
      tx_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            tx_ready_i  = 1'b0;
            prevPending = 0;
            stallCnt    = 0;
         end else begin
            if (prevPending)
               checkOutput("tx_hold", {tx_valid_o, tx_data_o}, {1'b1, prevData});
            if (stallMode) begin
               if (tx_valid_o && stallCnt < 3) begin
                  tx_ready_i = 1'b0;
                  stallCnt++;
               end else begin
                  tx_ready_i = 1'b1;
                  stallCnt   = 0;
               end
            end else begin
               tx_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (tx_valid_o && tx_ready_i) begin
               if (expBytes.size() == 0 && expReply.size() != 0) begin
                  kind = expReply.pop_front();
                  if (kind == 8'h52) begin
                     if (readData.size() == 0) begin
                        checkOutput("tx_read_without_rvalid", 64'd1, 64'd0);
                        rd = 32'h0;
                     end else begin
                        rd = readData.pop_front();
                     end
                     for (int i = 0; i < 4; i++) expBytes.push_back(rd[8*i +: 8]);
                  end else begin
                     expBytes.push_back(kind);
                  end
               end
               if (expBytes.size() == 0) begin
                  checkOutput("tx_unexpected", 64'(tx_data_o), 64'h100);
               end else begin
                  want = expBytes.pop_front();
                  checkOutput("tx_byte", 64'(tx_data_o), 64'(want));
               end
            end
            prevPending = tx_valid_o && !tx_ready_i;
            prevData    = tx_data_o;
         end
      end
   end

   initial begin
      logic [31:0] a;
      logic [31:0] w;
      logic [7:0]  c;
      int          n;
      int          kind;
      rst_ni     = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h0;
      repeat (3) @(negedge clk_i);
      checkResetOutputs("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);

      $display("[TB] directed write");
      gntDelay = 1;
      frame = '{8'h57, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      runFrame();
      waitDone("write_done");

      $display("[TB] directed read");
      fixedRdata = 1; fixedRdataVal = 32'h0000_0001;
      frame = '{8'h52, 8'h04, 8'h00, 8'h00, 8'h0F};
      runFrame();
      waitDone("read_done");

      $display("[TB] unknown command then read");
      fixedRdata = 0;
      frame = '{8'h33};
      runFrame();
      frame = '{8'h52, 8'h07, 8'h12, 8'h34, 8'h56};
      runFrame();
      waitDone("unknown_read_done");

      $display("[TB] stalled grant and transmitter");
      stallMode = 1;
      frame = '{8'h52, 8'h80, 8'h00, 8'h00, 8'h20};
      runFrame();
      frame = '{8'h57, 8'h84, 8'h00, 8'h00, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};
      runFrame();
      waitDone("stall_done");
      stallMode = 0;

      $display("[TB] random frames");
      gntDelay = -1;
      gapEn    = 1;
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 5);
         a = $urandom;
         w = $urandom;
         if (kind == 0) begin
            c = 8'($urandom);
            if (c == 8'h57 || c == 8'h52) c = c ^ 8'h01;
            frame = '{c};
         end else if (kind <= 2) begin
            frame = '{8'h57, a[7:0], a[15:8], a[23:16], a[31:24], w[7:0], w[15:8], w[23:16], w[31:24]};
         end else begin
            frame = '{8'h52, a[7:0], a[15:8], a[23:16], a[31:24]};
         end
         runFrame();
         if ($urandom_range(0, 4) == 0) waitDone("random_drain");
      end
      waitDone("random_done");
      gapEn = 0;

      $display("[TB] reset mid-frame");
      applyStimulus(8'h57);
      applyStimulus(8'h10);
      applyStimulus(8'h00);
      rst_ni = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk_i);
      checkResetOutputs("midreset_hold");
      rst_ni = 1'b1;
      @(negedge clk_i);
      frame = '{8'h52, 8'h3C, 8'h00, 8'h00, 8'h40};
      runFrame();
      waitDone("after_reset_done");

`ifdef BRIDGE_TIMEOUT_EN
      $display("[TB] grant timeout");
      busMute = 1;
      expReply.push_back(8'h45);
      frame = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00};
      foreach (frame[i]) applyStimulus(frame[i]);
      n = 0;
      while (obi_req_o && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      checkOutput("timeout_req_cycles", 64'(n), 64'd16);
      waitDone("timeout_done");
      repeat (10) @(negedge clk_i);
      checkOutput("timeout_idle", {tx_valid_o, busy_o}, 2'b00);
      busMute = 0;
`endif

      repeat (5) @(negedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
